muldiv_sched: RTL and testbench

//   Sequences the HI/LO multiply/divide resource for the 5-stage MIPS core.
//   - Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and models fixed multi-cycle latency.
//   - Owns the HI/LO registers and raises a stall request to hazard control while the unit is occupied.
//   - W-stage MFHI/MFLO data comes from hi/lo.

---
 rtl/muldiv_sched_if.sv | 24 ++
 rtl/muldiv_sched.sv | 120 ++++++++++++
 tb/tb_muldiv_sched.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sched_if.sv
// Handshake and data bundle between the E/D pipeline stages and the HI/LO
// multiply/divide sequencer.
interface muldiv_sched_if;
    logic        start;
    logic        cancel;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, cancel, op, a, b, md_use_d,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, cancel, op, a, b, md_use_d,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide sequencer: computes the result at accept, then holds the
// unit busy for a fixed cycle count before committing it to HI/LO.
module muldiv_sched #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_sched_if.slave md
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Full 64-bit product; operands are sign- or zero-extended before multiplying.
    function automatic logic [63:0] mul_full(input logic is_signed,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = is_signed ? $signed({{32{x[31]}}, x}) : $signed({32'h0, x});
        sy = is_signed ? $signed({{32{y[31]}}, y}) : $signed({32'h0, y});
        return $unsigned(sx * sy);
    endfunction

    // Returns {remainder, quotient}, saturating the divide-by-zero and overflow cases.
    function automatic logic [63:0] div_full(input logic is_signed,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        sx = $signed(x);
        sy = $signed(y);
        if (y == 32'h0)
            return {x, 32'hFFFF_FFFF};
        else if (is_signed && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return {32'h0, 32'h8000_0000};
        else if (is_signed)
            return {$unsigned(sx % sy), $unsigned(sx / sy)};
        else
            return {x % y, x / y};
    endfunction

    logic [0:0]  state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        go;
    logic [63:0] mul_res;
    logic [63:0] div_res;

    assign go      = md.start & ~md.cancel & (state_q == S_IDLE);
    assign mul_res = mul_full(~md.op[0], md.a, md.b);
    assign div_res = div_full(~md.op[0], md.a, md.b);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        if (state_q == S_IDLE) begin
            if (go) begin
                case (md.op)
                    3'd0, 3'd1: begin
                        {res_hi_d, res_lo_d} = mul_res;
                        count_d = 4'(MUL_CYCLES - 1);
                        state_d = S_RUN;
                    end
                    3'd2, 3'd3: begin
                        {res_hi_d, res_lo_d} = div_res;
                        count_d = 4'(DIV_CYCLES - 1);
                        state_d = S_RUN;
                    end
                    3'd4:    hi_d = md.a;
                    3'd5:    lo_d = md.a;
                    default: ;
                endcase
            end
        end else begin
            // cancel is deliberately ignored here: the running op predates the flush
            if (count_q == 4'd0) begin
                hi_d    = res_hi_q;
                lo_d    = res_lo_q;
                state_d = S_IDLE;
            end else begin
                count_d = count_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= 4'd0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        res_hi_q <= res_hi_d;
        res_lo_q <= res_lo_d;
    end

    assign md.busy      = (state_q == S_RUN);
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;
    assign md.stall_req = md.md_use_d &
                          ((state_q == S_RUN) | (md.start & ~md.cancel & (md.op <= 3'd3)));

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: stimulus pushes expected HI/LO commits with
// their due cycle; a negedge monitor checks busy, stall_req and commits.
module tb_muldiv_sched;

    localparam int MULN = 5;
    localparam int DIVN = 10;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   busy_until = 0;
    bit   mon_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] mhi = 32'h0;
    logic [31:0] mlo = 32'h0;
    exp_t sb_q[$];

    muldiv_sched_if md_if();

    muldiv_sched #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: plain 64-bit integer arithmetic, returns {hi, lo}.
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
        longint sx, sy, ux, uy, p, q, r;
        logic [63:0] pv, qv, rv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (o)
            3'd0: p = sx * sy;
            3'd1: p = ux * uy;
            default: p = 0;
        endcase
        pv = p;
        if (o <= 3'd1) return pv;
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (o == 3'd2) begin q = sx / sy; r = sx % sy; end
        else begin q = ux / uy; r = ux % uy; end
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Monitor: everything sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic eb, es;
            exp_t e;
            eb = (cyc < busy_until);
            es = md_if.md_use_d & (eb | (md_if.start & ~md_if.cancel & (md_if.op <= 3'd3)));
            chk("busy", {31'h0, md_if.busy}, {31'h0, eb});
            chk("stall_req", {31'h0, md_if.stall_req}, {31'h0, es});
            if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                e = sb_q.pop_front();
                chk("commit_missed_due", cyc, e.due);
            end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                chk("hi", md_if.hi, e.hi);
                chk("lo", md_if.lo, e.lo);
            end
        end
    end

    // Called #1 after a rising edge; issues one cycle of start and models acceptance.
    task automatic drive(input bit st, input bit cn, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y, input bit mu);
        int e_cyc;
        logic [63:0] r;
        exp_t e;
        md_if.start    = st;
        md_if.cancel   = cn;
        md_if.op       = o;
        md_if.a        = x;
        md_if.b        = y;
        md_if.md_use_d = mu;
        @(posedge clk);
        #1;
        e_cyc = cyc;
        if (st && !cn && (e_cyc - 1 >= busy_until)) begin
            if (o <= 3'd3) begin
                r = ref_op(o, x, y);
                mhi = r[63:32];
                mlo = r[31:0];
                busy_until = e_cyc + ((o <= 3'd1) ? MULN : DIVN);
                e.due = busy_until;
            end else begin
                if (o == 3'd4) mhi = x;
                if (o == 3'd5) mlo = x;
                e.due = e_cyc;
            end
            e.hi = mhi;
            e.lo = mlo;
            if (o <= 3'd5) sb_q.push_back(e);
        end
        md_if.start  = 1'b0;
        md_if.cancel = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (cyc < busy_until && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        drive(1'b1, 1'b0, o, x, y, 1'b0);
        wait_idle();
    endtask

    task automatic model_reset();
        busy_until = cyc;
        sb_q.delete();
        mhi = 32'h0;
        mlo = 32'h0;
    endtask

    initial begin
        md_if.start    = 1'b1;
        md_if.cancel   = 1'b0;
        md_if.op       = 3'd0;
        md_if.a        = 32'h5;
        md_if.b        = 32'h7;
        md_if.md_use_d = 1'b0;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset_busy", {31'h0, md_if.busy}, 32'h0);
        chk("reset_hi", md_if.hi, 32'h0);
        chk("reset_lo", md_if.lo, 32'h0);
        chk("reset_stall", {31'h0, md_if.stall_req}, 32'h0);
        md_if.start = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFD, 32'h5);
        chk("mult_hi", md_if.hi, 32'hFFFF_FFFF);
        chk("mult_lo", md_if.lo, 32'hFFFF_FFF1);
        run_op(3'd1, 32'hFFFF_FFFD, 32'h5);
        chk("multu_hi", md_if.hi, 32'h0000_0004);
        chk("multu_lo", md_if.lo, 32'hFFFF_FFF1);
        run_op(3'd3, 32'h7, 32'h2);
        chk("divu_hi", md_if.hi, 32'h1);
        chk("divu_lo", md_if.lo, 32'h3);
        run_op(3'd2, 32'hFFFF_FFF9, 32'h2);
        chk("div_hi", md_if.hi, 32'hFFFF_FFFF);
        chk("div_lo", md_if.lo, 32'hFFFF_FFFD);
        run_op(3'd2, 32'h9, 32'h0);
        chk("div0_hi", md_if.hi, 32'h9);
        chk("div0_lo", md_if.lo, 32'hFFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf_hi", md_if.hi, 32'h0);
        chk("divovf_lo", md_if.lo, 32'h8000_0000);

        // Hazard: D stage keeps using HI/LO for the whole MULT; MTHI during RUN is dropped.
        drive(1'b1, 1'b0, 3'd0, 32'hFFFF_FFFD, 32'h5, 1'b1);
        drive(1'b1, 1'b0, 3'd4, 32'hDEAD_BEEF, 32'h0, 1'b1);
        wait_idle();
        chk("mthi_in_run_hi", md_if.hi, 32'hFFFF_FFFF);
        md_if.md_use_d = 1'b0;

        run_op(3'd4, 32'h1234, 32'h0);
        chk("mthi_hi", md_if.hi, 32'h1234);
        drive(1'b1, 1'b1, 3'd5, 32'h5555, 32'h0, 1'b1);
        drive(1'b1, 1'b1, 3'd0, 32'h3, 32'h3, 1'b1);
        chk("cancel_hi", md_if.hi, 32'h1234);
        chk("cancel_lo", md_if.lo, 32'hFFFF_FFF1);
        wait_idle();

        // Reset in the third busy cycle of a DIV.
        drive(1'b1, 1'b0, 3'd2, 32'd100, 32'd7, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk("midrst_busy", {31'h0, md_if.busy}, 32'h0);
        chk("midrst_hi", md_if.hi, 32'h0);
        chk("midrst_lo", md_if.lo, 32'h0);

        for (int i = 0; i < 80; i++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            int          k;
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            k = $urandom_range(0, 7);
            if (k == 0) y = 32'h0;
            if (k == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if (k == 2) begin x = 32'($urandom_range(0, 40)) - 32'd20; y = 32'($urandom_range(0, 8)) - 32'd4; end
            drive(1'b1, ($urandom_range(0, 7) == 0), o, x, y, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) != 0) wait_idle();
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        md_if.md_use_d = 1'b0;
        wait_idle();
        repeat (2) begin @(posedge clk); #1; end
        chk("scoreboard_drained", sb_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
